// File: rtl/maq_mh_if.sv
// Button, tick and time-display bundle for the minutes/hours timekeeping stage.
// slave is the timekeeper side; master is whoever drives the pulses and reads the time.
interface maq_mh_if;
   logic       maq_mh_incremento_minuto;
   logic       maq_mh_btn_modo;
   logic       maq_mh_btn_inc;
   logic [3:0] maq_mh_bcd_m_lsd;
   logic [2:0] maq_mh_bcd_m_msd;
   logic [3:0] maq_mh_bcd_h_lsd;
   logic [1:0] maq_mh_bcd_h_msd;
   logic [1:0] maq_mh_modo;
   logic       maq_mh_incremento_dia;

   modport master (
      output maq_mh_incremento_minuto, maq_mh_btn_modo, maq_mh_btn_inc,
      input  maq_mh_bcd_m_lsd, maq_mh_bcd_m_msd, maq_mh_bcd_h_lsd,
             maq_mh_bcd_h_msd, maq_mh_modo, maq_mh_incremento_dia
   );

   modport slave (
      input  maq_mh_incremento_minuto, maq_mh_btn_modo, maq_mh_btn_inc,
      output maq_mh_bcd_m_lsd, maq_mh_bcd_m_msd, maq_mh_bcd_h_lsd,
             maq_mh_bcd_h_msd, maq_mh_modo, maq_mh_incremento_dia
   );
endinterface

// File: rtl/maq_mh.sv
// BCD minutes/hours counter fed by the seconds stage's minute tick, with a
// RUN -> SET_H -> SET_M set-time FSM and a one-cycle day carry at midnight.
module maq_mh #(
   parameter int RESET_H = 0,
   parameter int RESET_M = 0
) (
   input  logic    maq_mh_clock,
   input  logic    maq_mh_reset,
   maq_mh_if.slave mh
);
   localparam logic [3:0] RM_LSD = 4'(RESET_M % 10);
   localparam logic [2:0] RM_MSD = 3'(RESET_M / 10);
   localparam logic [3:0] RH_LSD = 4'(RESET_H % 10);
   localparam logic [1:0] RH_MSD = 2'(RESET_H / 10);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10
   } modo_t;

   modo_t      r_modo;
   logic [3:0] r_m_lsd;
   logic [2:0] r_m_msd;
   logic [3:0] r_h_lsd;
   logic [1:0] r_h_msd;
   logic       r_dia;

   // Incremented values of each field; the FSM decides which of them land.
   logic       w_m_lsd_wrap;
   logic       w_m_wrap;
   logic       w_h_lsd_wrap;
   logic       w_h_wrap;
   logic [3:0] w_m_lsd_nx;
   logic [2:0] w_m_msd_nx;
   logic [3:0] w_h_lsd_nx;
   logic [1:0] w_h_msd_nx;

   assign w_m_lsd_wrap = (r_m_lsd == 4'd9);
   assign w_m_wrap     = w_m_lsd_wrap && (r_m_msd == 3'd5);
   assign w_h_lsd_wrap = (r_h_lsd == 4'd9);
   assign w_h_wrap     = (r_h_msd == 2'd2) && (r_h_lsd == 4'd3);

   assign w_m_lsd_nx = w_m_lsd_wrap ? 4'd0 : r_m_lsd + 4'd1;
   assign w_m_msd_nx = w_m_wrap     ? 3'd0 :
                       w_m_lsd_wrap ? r_m_msd + 3'd1 : r_m_msd;
   assign w_h_lsd_nx = (w_h_wrap || w_h_lsd_wrap) ? 4'd0 : r_h_lsd + 4'd1;
   assign w_h_msd_nx = w_h_wrap     ? 2'd0 :
                       w_h_lsd_wrap ? r_h_msd + 2'd1 : r_h_msd;

   always_ff @(posedge maq_mh_clock or negedge maq_mh_reset) begin
      if (!maq_mh_reset) begin
         r_modo  <= RUN;
         r_m_lsd <= RM_LSD;
         r_m_msd <= RM_MSD;
         r_h_lsd <= RH_LSD;
         r_h_msd <= RH_MSD;
         r_dia   <= 1'b0;
      end else begin
         r_dia <= 1'b0;
         case (r_modo)
            RUN: begin
               // The tick still applies on the edge that leaves RUN.
               if (mh.maq_mh_incremento_minuto) begin
                  r_m_lsd <= w_m_lsd_nx;
                  r_m_msd <= w_m_msd_nx;
                  if (w_m_wrap) begin
                     r_h_lsd <= w_h_lsd_nx;
                     r_h_msd <= w_h_msd_nx;
                     r_dia   <= w_h_wrap;
                  end
               end
               if (mh.maq_mh_btn_modo) r_modo <= SET_H;
            end
            SET_H: begin
               if (mh.maq_mh_btn_modo) begin
                  r_modo <= SET_M;
               end else if (mh.maq_mh_btn_inc) begin
                  r_h_lsd <= w_h_lsd_nx;
                  r_h_msd <= w_h_msd_nx;
               end
            end
            SET_M: begin
               if (mh.maq_mh_btn_modo) begin
                  r_modo <= RUN;
               end else if (mh.maq_mh_btn_inc) begin
                  r_m_lsd <= w_m_lsd_nx;
                  r_m_msd <= w_m_msd_nx;
               end
            end
            default: r_modo <= RUN;
         endcase
      end
   end

   assign mh.maq_mh_bcd_m_lsd      = r_m_lsd;
   assign mh.maq_mh_bcd_m_msd      = r_m_msd;
   assign mh.maq_mh_bcd_h_lsd      = r_h_lsd;
   assign mh.maq_mh_bcd_h_msd      = r_h_msd;
   assign mh.maq_mh_modo           = r_modo;
   assign mh.maq_mh_incremento_dia = r_dia;
endmodule

// File: tb/tb_maq_mh.sv
// Self-checking bench for maq_mh: directed scenarios plus random pulses, all
// compared against a minutes-since-midnight reference model.
module tb_maq_mh;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   maq_mh_if bus ();

   maq_mh #(.RESET_H(0), .RESET_M(0)) dut (
      .maq_mh_clock (clk),
      .maq_mh_reset (rst_n),
      .mh           (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: plain integers for hours, minutes and mode.
   int mh_h, mh_m, mh_mode, mh_dia;

   task automatic model_reset();
      mh_h = 0; mh_m = 0; mh_mode = 0; mh_dia = 0;
   endtask

   task automatic model_step(input bit t, input bit bm, input bit bi);
      int total;
      mh_dia = 0;
      case (mh_mode)
         0: begin
            if (t) begin
               total = mh_h * 60 + mh_m + 1;
               if (total == 24 * 60) begin
                  total  = 0;
                  mh_dia = 1;
               end
               mh_h = total / 60;
               mh_m = total % 60;
            end
            if (bm) mh_mode = 1;
         end
         1: if (bm) mh_mode = 2; else if (bi) mh_h = (mh_h + 1) % 24;
         default: if (bm) mh_mode = 0; else if (bi) mh_m = (mh_m + 1) % 60;
      endcase
   endtask

   function automatic logic [15:0] model_vec();
      return {2'(mh_h / 10), 4'(mh_h % 10), 3'(mh_m / 10), 4'(mh_m % 10),
              2'(mh_mode), 1'(mh_dia)};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {bus.maq_mh_bcd_h_msd, bus.maq_mh_bcd_h_lsd, bus.maq_mh_bcd_m_msd,
              bus.maq_mh_bcd_m_lsd, bus.maq_mh_modo, bus.maq_mh_incremento_dia};
   endfunction

   // One clock cycle with the given inputs; returns at the following negedge.
   task automatic drive(input bit t, input bit bm, input bit bi);
      bus.maq_mh_incremento_minuto = t;
      bus.maq_mh_btn_modo          = bm;
      bus.maq_mh_btn_inc           = bi;
      @(posedge clk);
      model_step(t, bm, bi);
      @(negedge clk);
   endtask

   // Walks the model/DUT from RUN to the requested time and leaves it in mode md.
   task automatic goto_time(input int h, input int m, input int md);
      drive(0, 1, 0);
      while (mh_h != h) drive(0, 0, 1);
      drive(0, 1, 0);
      while (mh_m != m) drive(0, 0, 1);
      if (md == 0) drive(0, 1, 0);
      else if (md == 1) begin
         drive(0, 1, 0);
         drive(0, 1, 0);
      end
      drive(0, 0, 0);
   endtask

   task automatic test_reset();
      bus.maq_mh_incremento_minuto = 1'b0;
      bus.maq_mh_btn_modo          = 1'b0;
      bus.maq_mh_btn_inc           = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", dut_vec(), 16'h0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL reset_idle: got %h expected %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_run_60();
      for (int i = 0; i < 60; i++) begin
         drive(1, 0, 0);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL run_tick%0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      drive(0, 0, 0);
      checks++;
      if (dut_vec() !== {2'd0, 4'd1, 3'd0, 4'd0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL run_01_00: got %h expected %h", dut_vec(),
                  {2'd0, 4'd1, 3'd0, 4'd0, 2'd0, 1'b0});
      end
   endtask

   task automatic test_midnight();
      goto_time(23, 58, 0);
      checks++;
      if (dut_vec() !== {2'd2, 4'd3, 3'd5, 4'd8, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL set_23_58: got %h expected %h", dut_vec(),
                  {2'd2, 4'd3, 3'd5, 4'd8, 2'd0, 1'b0});
      end
      drive(1, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL tick_23_59: got %h expected %h", dut_vec(), model_vec());
      end
      drive(1, 0, 0);
      checks++;
      if (dut_vec() !== {2'd0, 4'd0, 3'd0, 4'd0, 2'd0, 1'b1}) begin
         errors++;
         $display("FAIL midnight_dia: got %h expected %h", dut_vec(),
                  {2'd0, 4'd0, 3'd0, 4'd0, 2'd0, 1'b1});
      end
      drive(0, 0, 0);
      checks++;
      if (bus.maq_mh_incremento_dia !== 1'b0) begin
         errors++;
         $display("FAIL dia_one_cycle: got %b expected 0", bus.maq_mh_incremento_dia);
      end
   endtask

   task automatic test_seth_wrap();
      drive(0, 1, 0);
      for (int i = 0; i < 24; i++) begin
         drive(0, 0, 1);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL seth_inc%0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
      checks++;
      if (dut_vec() !== {2'd0, 4'd0, 3'd0, 4'd0, 2'd1, 1'b0}) begin
         errors++;
         $display("FAIL seth_wrap: got %h expected %h", dut_vec(),
                  {2'd0, 4'd0, 3'd0, 4'd0, 2'd1, 1'b0});
      end
      drive(0, 1, 0);
      drive(0, 1, 0);
   endtask

   task automatic test_setm_frozen();
      goto_time(12, 59, 2);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0);
         checks++;
         if (dut_vec() !== {2'd1, 4'd2, 3'd5, 4'd9, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL setm_tick_lost%0d: got %h expected %h", i, dut_vec(),
                     {2'd1, 4'd2, 3'd5, 4'd9, 2'd2, 1'b0});
         end
      end
      drive(0, 0, 1);
      checks++;
      if (dut_vec() !== {2'd1, 4'd2, 3'd0, 4'd0, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL setm_wrap: got %h expected %h", dut_vec(),
                  {2'd1, 4'd2, 3'd0, 4'd0, 2'd2, 1'b0});
      end
      drive(0, 1, 0);
   endtask

   task automatic test_modo_inc_simul();
      drive(0, 1, 0);
      while (mh_h != 5) drive(0, 0, 1);
      drive(0, 1, 1);
      checks++;
      if (dut_vec() !== {2'd0, 4'd5, 3'd0, 4'd0, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL modo_wins: got %h expected %h", dut_vec(),
                  {2'd0, 4'd5, 3'd0, 4'd0, 2'd2, 1'b0});
      end
      drive(0, 1, 0);
   endtask

   task automatic test_async_reset();
      goto_time(10, 37, 2);
      checks++;
      if (dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL pre_reset_10_37: got %h expected %h", dut_vec(), model_vec());
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", dut_vec(), 16'h0000);
      end
      #1 rst_n = 1'b1;
      drive(0, 0, 0);
   endtask

   task automatic test_random();
      bit t, bm, bi;
      for (int i = 0; i < 1500; i++) begin
         t  = ($urandom % 4) != 0;
         bm = ($urandom % 10) == 0;
         bi = ($urandom % 3) == 0;
         drive(t, bm, bi);
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random%0d: got %h expected %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_run_60();
      test_midnight();
      test_seth_wrap();
      test_setm_frozen();
      test_modo_inc_simul();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
